ctrl_unit: RTL and testbench

- Hardwired, multi-cycle control unit for the 8-bit accumulator CPU.
- Runs the fetch/decode/execute sequence as a Moore FSM.
- Drives the 7-bit ALU function code that the datapath ALU consumes, plus all register-load, bus-select and memory strobes.
- Sits between the instruction register / zero flag (inputs) and the datapath (outputs).

---
 rtl/ctrl_unit_pkg.sv | 93 +++++++++
 rtl/ctrl_unit_if.sv | 35 +++
 rtl/ctrl_decode.sv | 69 ++++++
 rtl/ctrl_unit.sv | 74 +++++++
 tb/tb_ctrl_unit.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_unit_pkg.sv
// Shared encodings for the accumulator-CPU control unit: ALU codes, opcodes,
// bus selects, FSM states and the packed control-word bundle.
package ctrl_unit_pkg;

    localparam int ALUS_W = 7;
    localparam int IR_W   = 8;

    // Must match the datapath ALU function decoder exactly.
    localparam logic [ALUS_W-1:0] ALUS_NOP  = 7'd0;
    localparam logic [ALUS_W-1:0] ALUS_ADD  = 7'd1;
    localparam logic [ALUS_W-1:0] ALUS_SUB  = 7'd2;
    localparam logic [ALUS_W-1:0] ALUS_AND  = 7'd3;
    localparam logic [ALUS_W-1:0] ALUS_OR   = 7'd4;
    localparam logic [ALUS_W-1:0] ALUS_XOR  = 7'd5;
    localparam logic [ALUS_W-1:0] ALUS_INC  = 7'd6;
    localparam logic [ALUS_W-1:0] ALUS_CLR  = 7'd7;
    localparam logic [ALUS_W-1:0] ALUS_NOT  = 7'd8;
    localparam logic [ALUS_W-1:0] ALUS_PASS = 7'd9;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDAC = 4'h1;
    localparam logic [3:0] OP_STAC = 4'h2;
    localparam logic [3:0] OP_MVAC = 4'h3;
    localparam logic [3:0] OP_MOVR = 4'h4;
    localparam logic [3:0] OP_JUMP = 4'h5;
    localparam logic [3:0] OP_JMPZ = 4'h6;
    localparam logic [3:0] OP_JPNZ = 4'h7;
    localparam logic [3:0] OP_ADD  = 4'h8;
    localparam logic [3:0] OP_SUB  = 4'h9;
    localparam logic [3:0] OP_AND  = 4'hA;
    localparam logic [3:0] OP_OR   = 4'hB;
    localparam logic [3:0] OP_XOR  = 4'hC;
    localparam logic [3:0] OP_INC  = 4'hD;
    localparam logic [3:0] OP_CLAC = 4'hE;
    localparam logic [3:0] OP_NOT  = 4'hF;

    localparam logic [3:0] HALT_SUBCODE = 4'hF;

    localparam logic [1:0] BUS_NONE = 2'd0;
    localparam logic [1:0] BUS_R    = 2'd1;
    localparam logic [1:0] BUS_DR   = 2'd2;
    localparam logic [1:0] BUS_AC   = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH1 = 4'd1,
        S_FETCH2 = 4'd2,
        S_FETCH3 = 4'd3,
        S_DECODE = 4'd4,
        S_EXEC   = 4'd5,
        S_ADDR1  = 4'd6,
        S_ADDR2  = 4'd7,
        S_LD1    = 4'd8,
        S_LD2    = 4'd9,
        S_ST1    = 4'd10,
        S_ST2    = 4'd11,
        S_JMP2   = 4'd12,
        S_HALT   = 4'd13
    } state_t;

    typedef struct packed {
        logic [ALUS_W-1:0] alus;
        logic [1:0]        bus_sel;
        logic              ar_ld_pc;
        logic              ar_ld_dr;
        logic              pc_inc;
        logic              pc_ld;
        logic              dr_ld;
        logic              ir_ld;
        logic              ac_ld;
        logic              z_ld;
        logic              r_ld;
        logic              rd;
        logic              wr;
        logic              done;
        logic              halted;
    } ctrl_t;

    function automatic logic [ALUS_W-1:0] alu_code(input logic [3:0] op);
        case (op)
            OP_ADD:  return ALUS_ADD;
            OP_SUB:  return ALUS_SUB;
            OP_AND:  return ALUS_AND;
            OP_OR:   return ALUS_OR;
            OP_XOR:  return ALUS_XOR;
            OP_INC:  return ALUS_INC;
            OP_CLAC: return ALUS_CLR;
            OP_NOT:  return ALUS_NOT;
            default: return ALUS_NOP;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_unit_if.sv
// Control-unit <-> datapath bundle: IR/zero flag in, ALU code and strobes out.
interface ctrl_unit_if;
    import ctrl_unit_pkg::*;

    logic [IR_W-1:0]   ir;
    logic              z;
    logic [ALUS_W-1:0] alus;
    logic [1:0]        bus_sel;
    logic              ar_ld_pc;
    logic              ar_ld_dr;
    logic              pc_inc;
    logic              pc_ld;
    logic              dr_ld;
    logic              ir_ld;
    logic              ac_ld;
    logic              z_ld;
    logic              r_ld;
    logic              rd;
    logic              wr;
    logic              done;
    logic              halted;

    modport master (
        input  ir, z,
        output alus, bus_sel, ar_ld_pc, ar_ld_dr, pc_inc, pc_ld, dr_ld,
               ir_ld, ac_ld, z_ld, r_ld, rd, wr, done, halted
    );

    modport slave (
        output ir, z,
        input  alus, bus_sel, ar_ld_pc, ar_ld_dr, pc_inc, pc_ld, dr_ld,
               ir_ld, ac_ld, z_ld, r_ld, rd, wr, done, halted
    );

endinterface

// File: rtl/ctrl_decode.sv
// Moore output decode: current state (plus opcode, and z in JMP2) -> control word.
module ctrl_decode
    import ctrl_unit_pkg::*;
(
    input  state_t     state,
    input  logic [3:0] op,
    input  logic       z,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH1: ctrl.ar_ld_pc = 1'b1;
            S_FETCH2, S_ADDR1: begin
                ctrl.rd     = 1'b1;
                ctrl.dr_ld  = 1'b1;
                ctrl.pc_inc = 1'b1;
            end
            S_FETCH3: ctrl.ir_ld = 1'b1;
            S_EXEC: begin
                ctrl.done = 1'b1;
                if (op[3]) begin
                    ctrl.alus    = alu_code(op);
                    ctrl.bus_sel = BUS_R;
                    ctrl.ac_ld   = 1'b1;
                    ctrl.z_ld    = 1'b1;
                end else if (op == OP_MVAC) begin
                    ctrl.bus_sel = BUS_AC;
                    ctrl.r_ld    = 1'b1;
                end else if (op == OP_MOVR) begin
                    ctrl.alus    = ALUS_PASS;
                    ctrl.bus_sel = BUS_R;
                    ctrl.ac_ld   = 1'b1;
                    ctrl.z_ld    = 1'b1;
                end
            end
            S_ADDR2: ctrl.ar_ld_dr = 1'b1;
            S_LD1: begin
                ctrl.rd    = 1'b1;
                ctrl.dr_ld = 1'b1;
            end
            S_LD2: begin
                ctrl.alus    = ALUS_PASS;
                ctrl.bus_sel = BUS_DR;
                ctrl.ac_ld   = 1'b1;
                ctrl.z_ld    = 1'b1;
                ctrl.done    = 1'b1;
            end
            S_ST1: begin
                ctrl.bus_sel = BUS_AC;
                ctrl.dr_ld   = 1'b1;
            end
            S_ST2: begin
                ctrl.wr   = 1'b1;
                ctrl.done = 1'b1;
            end
            S_JMP2: begin
                ctrl.done  = 1'b1;
                ctrl.pc_ld = (op == OP_JUMP) ||
                             (op == OP_JMPZ && z) ||
                             (op == OP_JPNZ && !z);
            end
            S_HALT: ctrl.halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/ctrl_unit.sv
// Hardwired multi-cycle control unit: state register, next-state logic and
// the ctrl_decode output stage driving the datapath bundle.
module ctrl_unit
    import ctrl_unit_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    ctrl_unit_if.master  cu
);

    state_t     state;
    state_t     next_state;
    logic [3:0] op;
    ctrl_t      ctrl;

    assign op = cu.ir[IR_W-1:IR_W-4];

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // NOTE: next_state gets a default before the case so no path can infer a latch.
    always_comb begin
        next_state = S_IDLE;
        case (state)
            S_IDLE:   next_state = S_FETCH1;
            S_FETCH1: next_state = S_FETCH2;
            S_FETCH2: next_state = S_FETCH3;
            S_FETCH3: next_state = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_NOP:  next_state = (cu.ir[3:0] == HALT_SUBCODE) ? S_HALT : S_EXEC;
                    OP_LDAC, OP_STAC, OP_JUMP, OP_JMPZ, OP_JPNZ:
                             next_state = S_ADDR1;
                    default: next_state = S_EXEC;
                endcase
            end
            S_ADDR1:  next_state = (op == OP_LDAC || op == OP_STAC) ? S_ADDR2 : S_JMP2;
            S_ADDR2:  next_state = (op == OP_LDAC) ? S_LD1 : S_ST1;
            S_LD1:    next_state = S_LD2;
            S_ST1:    next_state = S_ST2;
            S_EXEC, S_LD2, S_ST2, S_JMP2:
                      next_state = S_FETCH1;
            S_HALT:   next_state = S_HALT;
            default:  next_state = S_IDLE;
        endcase
    end

    ctrl_decode u_decode (
        .state (state),
        .op    (op),
        .z     (cu.z),
        .ctrl  (ctrl)
    );

    assign cu.alus     = ctrl.alus;
    assign cu.bus_sel  = ctrl.bus_sel;
    assign cu.ar_ld_pc = ctrl.ar_ld_pc;
    assign cu.ar_ld_dr = ctrl.ar_ld_dr;
    assign cu.pc_inc   = ctrl.pc_inc;
    assign cu.pc_ld    = ctrl.pc_ld;
    assign cu.dr_ld    = ctrl.dr_ld;
    assign cu.ir_ld    = ctrl.ir_ld;
    assign cu.ac_ld    = ctrl.ac_ld;
    assign cu.z_ld     = ctrl.z_ld;
    assign cu.r_ld     = ctrl.r_ld;
    assign cu.rd       = ctrl.rd;
    assign cu.wr       = ctrl.wr;
    assign cu.done     = ctrl.done;
    assign cu.halted   = ctrl.halted;

endmodule

// File: tb/tb_ctrl_unit.sv
// Self-checking bench for ctrl_unit: directed table, reset/HALT sequences and
// random instructions against a per-instruction microstep reference list.
module tb_ctrl_unit;

    logic clk;
    logic rst;

    ctrl_unit_if cu_if ();

    ctrl_unit dut (
        .clk (clk),
        .rst (rst),
        .cu  (cu_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0]  alus;
        logic [1:0]  bus_sel;
        logic [12:0] s;
    } vec_t;

    localparam logic [12:0] ARPC  = 13'h1000;
    localparam logic [12:0] ARDR  = 13'h0800;
    localparam logic [12:0] PCINC = 13'h0400;
    localparam logic [12:0] PCLD  = 13'h0200;
    localparam logic [12:0] DRLD  = 13'h0100;
    localparam logic [12:0] IRLD  = 13'h0080;
    localparam logic [12:0] ACLD  = 13'h0040;
    localparam logic [12:0] ZLD   = 13'h0020;
    localparam logic [12:0] RLD   = 13'h0010;
    localparam logic [12:0] RD    = 13'h0008;
    localparam logic [12:0] WR    = 13'h0004;
    localparam logic [12:0] DONE  = 13'h0002;
    localparam logic [12:0] HLT   = 13'h0001;

    typedef struct {
        logic [7:0] ir;
        logic       z;
        int         lat;
        vec_t       last;
    } tvec_t;

    int    tests = 0;
    int    fails = 0;
    vec_t  exp_q[$];
    tvec_t tbl[$];

    function automatic vec_t mk(input int a, input int b, input logic [12:0] s);
        vec_t v;
        v.alus    = 7'(a);
        v.bus_sel = 2'(b);
        v.s       = s;
        return v;
    endfunction

    function automatic vec_t sample();
        vec_t v;
        v.alus    = cu_if.alus;
        v.bus_sel = cu_if.bus_sel;
        v.s = {cu_if.ar_ld_pc, cu_if.ar_ld_dr, cu_if.pc_inc, cu_if.pc_ld,
               cu_if.dr_ld, cu_if.ir_ld, cu_if.ac_ld, cu_if.z_ld, cu_if.r_ld,
               cu_if.rd, cu_if.wr, cu_if.done, cu_if.halted};
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Reference: the per-clock strobe list of one instruction, from fetch to done.
    task automatic build_expected(input logic [7:0] ir, input logic zv);
        logic [3:0] op;
        logic       taken;
        op = ir[7:4];
        exp_q.delete();
        exp_q.push_back(mk(0, 0, ARPC));
        exp_q.push_back(mk(0, 0, RD | DRLD | PCINC));
        exp_q.push_back(mk(0, 0, IRLD));
        exp_q.push_back(mk(0, 0, 13'h0));
        if (ir == 8'h0F)       exp_q.push_back(mk(0, 0, HLT));
        else if (op == 4'h0)   exp_q.push_back(mk(0, 0, DONE));
        else if (op >= 4'h8)   exp_q.push_back(mk(int'(op) - 7, 1, ACLD | ZLD | DONE));
        else if (op == 4'h3)   exp_q.push_back(mk(0, 3, RLD | DONE));
        else if (op == 4'h4)   exp_q.push_back(mk(9, 1, ACLD | ZLD | DONE));
        else begin
            exp_q.push_back(mk(0, 0, RD | DRLD | PCINC));
            if (op == 4'h1) begin
                exp_q.push_back(mk(0, 0, ARDR));
                exp_q.push_back(mk(0, 0, RD | DRLD));
                exp_q.push_back(mk(9, 2, ACLD | ZLD | DONE));
            end else if (op == 4'h2) begin
                exp_q.push_back(mk(0, 0, ARDR));
                exp_q.push_back(mk(0, 3, DRLD));
                exp_q.push_back(mk(0, 0, WR | DONE));
            end else begin
                taken = (op == 4'h5) || (op == 4'h6 && zv) || (op == 4'h7 && !zv);
                exp_q.push_back(mk(0, 0, (taken ? PCLD : 13'h0) | DONE));
            end
        end
    endtask

    // Starts at the FETCH1 sample point; returns at the next instruction's FETCH1.
    // With noisy set, z carries the intended value only in clock 6 (JMP2).
    task automatic run_instr(input logic [7:0] ir, input logic zv, input bit noisy,
                             output int lat, output vec_t last);
        vec_t act;
        build_expected(ir, zv);
        lat  = 0;
        last = '0;
        cu_if.ir = ir;
        for (int k = 0; k < 16; k++) begin
            cu_if.z = (noisy && k != 5) ? 1'($urandom_range(0, 1)) : zv;
            #1;
            act = sample();
            if (k < exp_q.size())
                check($sformatf("ir%02h_clk%0d", ir, k + 1), 32'(act), 32'(exp_q[k]));
            else
                check($sformatf("ir%02h_no_done_clk%0d", ir, k + 1), 32'(act.s[1]), 32'd1);
            @(negedge clk);
            if (act.s[1]) begin
                lat  = k + 1;
                last = act;
                break;
            end
        end
    endtask

    // Assert rst at the current sample point, check the immediate drop, release,
    // and confirm FETCH1 follows one clock later.
    task automatic reset_restart(input string tag);
        rst = 1'b1;
        #1 check({tag, "_rst_async"}, 32'(sample()), 32'h0);
        @(negedge clk);
        check({tag, "_rst_held"}, 32'(sample()), 32'h0);
        rst = 1'b0;
        #1 check({tag, "_idle"}, 32'(sample()), 32'h0);
        @(negedge clk);
        #1 check({tag, "_fetch1"}, 32'(sample()), 32'(mk(0, 0, ARPC)));
    endtask

    int   lat;
    vec_t last;

    initial begin
        rst      = 1'b1;
        cu_if.ir = 8'h00;
        cu_if.z  = 1'b0;

        tbl.push_back('{8'h80, 1'b0, 5, mk(1, 1, ACLD | ZLD | DONE)});
        tbl.push_back('{8'hF0, 1'b0, 5, mk(8, 1, ACLD | ZLD | DONE)});
        tbl.push_back('{8'h93, 1'b1, 5, mk(2, 1, ACLD | ZLD | DONE)});
        tbl.push_back('{8'hD0, 1'b0, 5, mk(6, 1, ACLD | ZLD | DONE)});
        tbl.push_back('{8'hE0, 1'b0, 5, mk(7, 1, ACLD | ZLD | DONE)});
        tbl.push_back('{8'h00, 1'b0, 5, mk(0, 0, DONE)});
        tbl.push_back('{8'h30, 1'b0, 5, mk(0, 3, RLD | DONE)});
        tbl.push_back('{8'h40, 1'b0, 5, mk(9, 1, ACLD | ZLD | DONE)});
        tbl.push_back('{8'h10, 1'b0, 8, mk(9, 2, ACLD | ZLD | DONE)});
        tbl.push_back('{8'h20, 1'b0, 8, mk(0, 0, WR | DONE)});
        tbl.push_back('{8'h50, 1'b0, 6, mk(0, 0, PCLD | DONE)});
        tbl.push_back('{8'h60, 1'b1, 6, mk(0, 0, PCLD | DONE)});
        tbl.push_back('{8'h60, 1'b0, 6, mk(0, 0, DONE)});
        tbl.push_back('{8'h70, 1'b0, 6, mk(0, 0, PCLD | DONE)});
        tbl.push_back('{8'h70, 1'b1, 6, mk(0, 0, DONE)});

        repeat (3) @(negedge clk);
        #1 check("reset_outputs", 32'(sample()), 32'h0);
        rst = 1'b0;
        #1 check("idle_outputs", 32'(sample()), 32'h0);
        @(negedge clk);

        foreach (tbl[i]) begin
            run_instr(tbl[i].ir, tbl[i].z, 1'b0, lat, last);
            check($sformatf("tbl%0d_latency", i), 32'(lat), 32'(tbl[i].lat));
            check($sformatf("tbl%0d_final", i), 32'(last), 32'(tbl[i].last));
        end

        // rst during FETCH2 of an ADD
        cu_if.ir = 8'h80;
        @(negedge clk);
        #1 check("fetch2_before_rst", 32'(sample()), 32'(mk(0, 0, RD | DRLD | PCINC)));
        reset_restart("mid_fetch2");

        // rst during ST2: the write strobe must vanish in the same cycle
        cu_if.ir = 8'h20;
        repeat (7) @(negedge clk);
        #1 check("st2_before_rst", 32'(sample()), 32'(mk(0, 0, WR | DONE)));
        reset_restart("mid_st2");

        // Random instructions, z toggling outside JMP2
        for (int n = 0; n < 300; n++) begin
            logic [7:0] rir;
            rir = 8'($urandom_range(0, 255));
            if (rir == 8'h0F) rir = 8'h00;
            run_instr(rir, 1'($urandom_range(0, 1)), 1'b1, lat, last);
        end

        // HALT: fetch, then halted only, immune to ir/z, until reset
        build_expected(8'h0F, 1'b0);
        cu_if.ir = 8'h0F;
        for (int k = 0; k < 5; k++) begin
            #1 check($sformatf("halt_clk%0d", k + 1), 32'(sample()), 32'(exp_q[k]));
            @(negedge clk);
        end
        for (int k = 0; k < 20; k++) begin
            cu_if.ir = 8'($urandom_range(0, 255));
            cu_if.z  = 1'($urandom_range(0, 1));
            #1 check($sformatf("halt_hold%0d", k), 32'(sample()), 32'(mk(0, 0, HLT)));
            @(negedge clk);
        end
        reset_restart("halt_exit");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests);
        $fatal(1, "watchdog");
    end

endmodule
